// File: rtl/parity_scanner.sv
// Multi-bit-per-cycle parity engine: captures a word on start, counts its ones
// STEP bits per clock, then reports the ones count, parity and a parity-check result.
module parity_scanner #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 1,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  odd_mode,
    input  logic                  parity_bit_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      one_count,
    output logic                  even_parity,
    output logic                  odd_parity,
    output logic                  parity_error
);

    localparam int N     = DATA_WIDTH / STEP;
    localparam int REM_W = (N > 1) ? $clog2(N + 1) : 1;

    generate
        if (DATA_WIDTH < 1 || STEP < 1 || (DATA_WIDTH % STEP) != 0) begin : g_bad_params
            $error("parity_scanner: STEP must be >= 1 and divide DATA_WIDTH (>= 1)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        acc_q, acc_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic                    mode_q, mode_d;
    logic                    pbit_q, pbit_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    even_q, even_d;
    logic                    odd_q, odd_d;
    logic                    perr_q, perr_d;
    logic [CNT_W-1:0]        acc_sum;

    function automatic logic [CNT_W-1:0] popcount(input logic [STEP-1:0] bits);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < STEP; i++) begin
            n = n + CNT_W'(bits[i]);
        end
        return n;
    endfunction

    // Running total including the slice consumed on this edge; on the last
    // SCAN edge this is the final count registered into the outputs.
    assign acc_sum = acc_q + popcount(shift_q[STEP-1:0]);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        pbit_d  = pbit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        even_d  = even_q;
        odd_d   = odd_q;
        perr_d  = perr_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shift_d = data_in;
                    mode_d  = odd_mode;
                    pbit_d  = parity_bit_in;
                    acc_d   = '0;
                    rem_d   = REM_W'(N);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d   = acc_sum;
                shift_d = shift_q >> STEP;
                rem_d   = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    count_d = acc_sum;
                    even_d  = ~acc_sum[0];
                    odd_d   = acc_sum[0];
                    // Word ones + received bit must have the parity odd_mode selects.
                    perr_d  = acc_sum[0] ^ pbit_q ^ mode_q;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            pbit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            even_q  <= 1'b0;
            odd_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            pbit_q  <= pbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            perr_q  <= perr_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign one_count    = count_q;
    assign even_parity  = even_q;
    assign odd_parity   = odd_q;
    assign parity_error = perr_q;

endmodule

// File: tb/tb_parity_scanner.sv
// Bench for parity_scanner: an 8-bit/STEP=1 and a 16-bit/STEP=4 instance checked
// every cycle against a countdown model, plus directed hand-computed expectations.
module tb_parity_scanner;

    localparam int N8  = 8;
    localparam int N16 = 4;

    logic        clk = 1'b0;
    logic        rst8 = 1'b0, rst16 = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  din8 = '0;
    logic [15:0] din16 = '0;
    logic        mode8 = 1'b0, mode16 = 1'b0, pb8 = 1'b0, pb16 = 1'b0;
    logic        busy8, done8, even8, odd8, perr8;
    logic        busy16, done16, even16, odd16, perr16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    parity_scanner #(.DATA_WIDTH(8), .STEP(1)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .data_in(din8), .odd_mode(mode8),
        .parity_bit_in(pb8), .busy(busy8), .done(done8), .one_count(cnt8),
        .even_parity(even8), .odd_parity(odd8), .parity_error(perr8)
    );

    parity_scanner #(.DATA_WIDTH(16), .STEP(4)) u16 (
        .clk(clk), .rst(rst16), .start(start16), .data_in(din16), .odd_mode(mode16),
        .parity_bit_in(pb16), .busy(busy16), .done(done16), .one_count(cnt16),
        .even_parity(even16), .odd_parity(odd16), .parity_error(perr16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level model: rem counts remaining busy cycles after acceptance.
    int m8_rem = 0, m8_ones = 0, m16_rem = 0, m16_ones = 0;
    bit m8_mode, m8_pb, m16_mode, m16_pb;
    logic [3:0] e8_cnt = '0;
    logic [4:0] e16_cnt = '0;
    bit e8_even, e8_odd, e8_perr, e16_even, e16_odd, e16_perr;

    always @(posedge clk or posedge rst8) begin
        if (rst8) begin
            m8_rem = 0; e8_cnt = '0; e8_even = 0; e8_odd = 0; e8_perr = 0;
        end else if (m8_rem == 0) begin
            if (start8) begin
                m8_ones = $countones(din8); m8_mode = mode8; m8_pb = pb8; m8_rem = N8 + 1;
            end
        end else begin
            m8_rem--;
            if (m8_rem == 1) begin
                e8_cnt  = 4'(m8_ones);
                e8_even = (m8_ones % 2) == 0;
                e8_odd  = !e8_even;
                e8_perr = ((m8_ones + int'(m8_pb)) % 2) != int'(m8_mode);
            end
        end
    end

    always @(posedge clk or posedge rst16) begin
        if (rst16) begin
            m16_rem = 0; e16_cnt = '0; e16_even = 0; e16_odd = 0; e16_perr = 0;
        end else if (m16_rem == 0) begin
            if (start16) begin
                m16_ones = $countones(din16); m16_mode = mode16; m16_pb = pb16; m16_rem = N16 + 1;
            end
        end else begin
            m16_rem--;
            if (m16_rem == 1) begin
                e16_cnt  = 5'(m16_ones);
                e16_even = (m16_ones % 2) == 0;
                e16_odd  = !e16_even;
                e16_perr = ((m16_ones + int'(m16_pb)) % 2) != int'(m16_mode);
            end
        end
    end

    always @(negedge clk) begin
        check("cycle_u8", 32'({busy8, done8, cnt8, even8, odd8, perr8}),
              32'({m8_rem != 0, m8_rem == 1, e8_cnt, e8_even, e8_odd, e8_perr}));
        check("cycle_u16", 32'({busy16, done16, cnt16, even16, odd16, perr16}),
              32'({m16_rem != 0, m16_rem == 1, e16_cnt, e16_even, e16_odd, e16_perr}));
    end

    task automatic run(input bit sel, input logic [15:0] d, input bit m, input bit p,
                       output int bcyc, output int dcnt, output int dat, output int cnt,
                       output bit ev, output bit od, output bit pe);
        bit b;
        bcyc = 0; dcnt = 0; dat = 0; cnt = -1; ev = 0; od = 0; pe = 0;
        @(posedge clk); #1;
        if (sel) begin din16 = d; mode16 = m; pb16 = p; start16 = 1'b1; end
        else begin din8 = d[7:0]; mode8 = m; pb8 = p; start8 = 1'b1; end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            b = sel ? busy16 : busy8;
            if (!b) break;
            bcyc++;
            if (sel ? done16 : done8) begin
                dcnt++; dat = bcyc;
                cnt = sel ? int'(cnt16) : int'(cnt8);
                ev = sel ? even16 : even8; od = sel ? odd16 : odd8; pe = sel ? perr16 : perr8;
            end
        end
    endtask

    int bc, dc, da, ct, dones, gap;
    bit ev, od, pe;
    int res[2];

    initial begin
        #1 rst8 = 1'b1; rst16 = 1'b1;
        @(negedge clk);
        check("reset_u8", 32'({busy8, done8, cnt8, even8, odd8, perr8}), 32'h0);
        check("reset_u16", 32'({busy16, done16, cnt16, even16, odd16, perr16}), 32'h0);
        @(posedge clk); #2 rst8 = 1'b0; rst16 = 1'b0;

        // 0xB5 = 5 ones, even mode, parity bit 1 -> consistent
        run(0, 16'h00B5, 0, 1, bc, dc, da, ct, ev, od, pe);
        check("b5_busy_cycles", bc, 9);
        check("b5_done_count", dc, 1);
        check("b5_done_at", da, 9);
        check("b5_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd5, 5'b0, 1'b0, 1'b1, 1'b0});

        run(0, 16'h0000, 1, 0, bc, dc, da, ct, ev, od, pe);
        check("zero_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd0, 5'b0, 1'b1, 1'b0, 1'b1});
        run(0, 16'h00FF, 1, 1, bc, dc, da, ct, ev, od, pe);
        check("ff_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd8, 5'b0, 1'b1, 1'b0, 1'b0});

        // 16-bit, 4 bits per cycle
        run(1, 16'hFFFF, 0, 0, bc, dc, da, ct, ev, od, pe);
        check("ffff_busy_cycles", bc, 5);
        check("ffff_done_at", da, 5);
        check("ffff_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd16, 5'b0, 1'b1, 1'b0, 1'b0});
        run(1, 16'h8001, 1, 1, bc, dc, da, ct, ev, od, pe);
        check("8001_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd2, 5'b0, 1'b1, 1'b0, 1'b0});
        run(1, 16'h0007, 0, 0, bc, dc, da, ct, ev, od, pe);
        check("0007_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd3, 5'b0, 1'b0, 1'b1, 1'b1});

        // start held high: back-to-back runs, data change mid-scan
        @(posedge clk); #1;
        din8 = 8'h5A; mode8 = 0; pb8 = 0; start8 = 1'b1;
        dones = 0; gap = 0; res[0] = -1; res[1] = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 3) din8 = 8'h01;
            if (done8) begin
                res[dones] = int'(cnt8);
                dones++;
                if (dones == 2) begin start8 = 1'b0; break; end
            end
            if (dones == 1 && !busy8) gap++;
        end
        check("held_dones", dones, 2);
        check("held_first_result", res[0], 4);
        check("held_second_result", res[1], 1);
        check("held_idle_gap", gap, 1);
        repeat (2) @(posedge clk);

        // asynchronous reset in the 3rd SCAN cycle
        @(posedge clk); #1;
        din8 = 8'h3C; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b1;
        #1 check("async_reset", 32'({busy8, done8, cnt8, even8, odd8, perr8}), 32'h0);
        @(posedge clk); #3 rst8 = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dc++;
        end
        check("no_done_after_abort", dc, 0);
        run(0, 16'h000F, 0, 0, bc, dc, da, ct, ev, od, pe);
        check("0f_busy_cycles", bc, 9);
        check("0f_result", {ct[7:0], 5'b0, ev, od, pe}, {8'd4, 5'b0, 1'b1, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
